// File: rtl/eeprom_page_ctrl.sv
// EEPROM page-write controller: splits host writes at page boundaries, waits out the
// internal write cycle after each page, and passes reads through as one sequential command.
module eeprom_page_ctrl #(
  parameter int P_ADDR_WIDTH  = 16,
  parameter int P_LEN_WIDTH   = 8,
  parameter int P_PAGE_SIZE   = 16,
  parameter int P_TWR_CYCLES  = 250000,
  parameter int P_WFIFO_DEPTH = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [2:0]              i_ctrl_eeprom_addr,
  input  logic [P_ADDR_WIDTH-1:0] i_ctrl_operation_addr,
  input  logic [P_LEN_WIDTH-1:0]  i_ctrl_operation_len,
  input  logic                    i_ctrl_operation_type,
  input  logic                    i_ctrl_operation_valid,
  output logic                    o_ctrl_operation_ready,
  input  logic [7:0]              i_ctrl_write_data,
  input  logic                    i_ctrl_write_valid,
  output logic                    o_ctrl_write_ready,
  output logic [7:0]              o_ctrl_read_data,
  output logic                    o_ctrl_read_valid,
  output logic                    o_ctrl_done,
  output logic [6:0]              o_driver_addr,
  output logic [P_ADDR_WIDTH-1:0] o_operation_addr,
  output logic [P_LEN_WIDTH-1:0]  o_operation_len,
  output logic                    o_operation_type,
  output logic                    o_operation_valid,
  input  logic                    i_operation_ready,
  output logic [7:0]              o_write_data,
  input  logic                    i_write_req,
  input  logic [7:0]              i_read_data,
  input  logic                    i_read_valid,
  output logic [2:0]              o_dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_FILL  = 3'd1;
  localparam logic [2:0] S_WR_REQ   = 3'd2;
  localparam logic [2:0] S_WR_BUSY  = 3'd3;
  localparam logic [2:0] S_TWR_WAIT = 3'd4;
  localparam logic [2:0] S_RD_REQ   = 3'd5;
  localparam logic [2:0] S_RD_BUSY  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam int PB  = $clog2(P_PAGE_SIZE);
  localparam int CW  = (P_LEN_WIDTH + 1 > PB + 1) ? P_LEN_WIDTH + 1 : PB + 1;
  localparam int FAW = $clog2(P_WFIFO_DEPTH);
  localparam int XW  = (FAW + 1 > CW) ? FAW + 1 : CW;
  localparam int TW  = $clog2(P_TWR_CYCLES + 1);

  localparam logic [FAW:0]  FIFO_FULL = (FAW + 1)'(P_WFIFO_DEPTH);
  localparam logic [TW-1:0] TWR_LAST  = TW'(P_TWR_CYCLES - 1);

  // Handshakes: a transfer happens on a rising i_clk edge where valid and ready are both
  // high; valid holds its payload until that edge, ready may change freely.
  logic [2:0]              state;
  logic                    pend;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_LEN_WIDTH-1:0]  rem_q;
  logic                    type_q;
  logic [2:0]              dev_q;
  logic [TW-1:0]           twr_cnt;
  logic                    ready_prev;

  logic [7:0]     fifo_mem [P_WFIFO_DEPTH];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   fill;
  logic           push;
  logic           pop;

  logic [PB-1:0]          page_off;
  logic [CW-1:0]          page_space;
  logic [CW-1:0]          rem_ext;
  logic [CW-1:0]          chunk_w;
  logic [P_LEN_WIDTH-1:0] chunk;
  logic                   fill_ok;
  logic                   cmd_hs;
  logic                   drv_rise;

  assign push = i_ctrl_write_valid && o_ctrl_write_ready;
  assign pop  = i_write_req && (fill != '0);
  assign o_ctrl_write_ready = (fill != FIFO_FULL);

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_ctrl_write_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      o_write_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + FAW'(1);
        o_write_data <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fill <= fill + (FAW + 1)'(1);
        2'b01:   fill <= fill - (FAW + 1)'(1);
        default: ;
      endcase
    end
  end

  // A page write may not cross the page boundary, so the chunk is capped by the room left.
  assign page_off   = addr_q[PB-1:0];
  assign page_space = CW'(P_PAGE_SIZE) - CW'(page_off);
  assign rem_ext    = CW'(rem_q);
  assign chunk_w    = (rem_ext < page_space) ? rem_ext : page_space;
  assign chunk      = chunk_w[P_LEN_WIDTH-1:0];
  assign fill_ok    = (XW'(fill) >= XW'(chunk_w));

  assign cmd_hs   = i_ctrl_operation_valid && o_ctrl_operation_ready;
  assign drv_rise = i_operation_ready && !ready_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      pend       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      type_q     <= 1'b0;
      dev_q      <= '0;
      twr_cnt    <= '0;
      ready_prev <= 1'b0;
    end else begin
      ready_prev <= i_operation_ready;
      if (cmd_hs) begin
        pend   <= 1'b1;
        addr_q <= i_ctrl_operation_addr;
        rem_q  <= i_ctrl_operation_len;
        type_q <= i_ctrl_operation_type;
        dev_q  <= i_ctrl_eeprom_addr;
      end
      case (state)
        S_IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            if (rem_q == '0)  state <= S_DONE;
            else if (!type_q) state <= S_WR_FILL;
            else              state <= S_RD_REQ;
          end
        end
        S_WR_FILL: if (fill_ok) state <= S_WR_REQ;
        S_WR_REQ:  if (i_operation_ready) state <= S_WR_BUSY;
        S_WR_BUSY: begin
          if (drv_rise) begin
            addr_q  <= addr_q + P_ADDR_WIDTH'(chunk);
            rem_q   <= rem_q - chunk;
            twr_cnt <= '0;
            state   <= S_TWR_WAIT;
          end
        end
        S_TWR_WAIT: begin
          if (twr_cnt == TWR_LAST) begin
            twr_cnt <= '0;
            state   <= (rem_q != '0) ? S_WR_FILL : S_DONE;
          end else begin
            twr_cnt <= twr_cnt + TW'(1);
          end
        end
        S_RD_REQ:  if (i_operation_ready) state <= S_RD_BUSY;
        S_RD_BUSY: if (drv_rise) state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ctrl_read_valid <= 1'b0;
      o_ctrl_read_data  <= '0;
    end else begin
      o_ctrl_read_valid <= i_read_valid;
      o_ctrl_read_data  <= i_read_data;
    end
  end

  // Driver outputs are forced to zero whenever no command is being offered.
  assign o_ctrl_operation_ready = (state == S_IDLE) && !pend;
  assign o_operation_valid      = (state == S_WR_REQ) || (state == S_RD_REQ);
  assign o_driver_addr          = o_operation_valid ? {4'b1010, dev_q} : '0;
  assign o_operation_addr       = o_operation_valid ? addr_q : '0;
  assign o_operation_len        = (state == S_WR_REQ) ? chunk :
                                  (state == S_RD_REQ) ? rem_q : '0;
  assign o_operation_type       = (state == S_RD_REQ);
  assign o_ctrl_done            = (state == S_DONE);
  assign o_dbg_state            = state;

endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// Directed bench for eeprom_page_ctrl: a page-splitting model feeds expected driver commands,
// write bytes and read echoes; a driver model plays the I2C engine.
module tb_eeprom_page_ctrl;
  localparam int TWR  = 20;
  localparam int PAGE = 16;

  logic       i_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] i_ctrl_eeprom_addr;
  logic [15:0] i_ctrl_operation_addr;
  logic [7:0] i_ctrl_operation_len;
  logic       i_ctrl_operation_type;
  logic       i_ctrl_operation_valid;
  logic       o_ctrl_operation_ready;
  logic [7:0] i_ctrl_write_data;
  logic       i_ctrl_write_valid;
  logic       o_ctrl_write_ready;
  logic [7:0] o_ctrl_read_data;
  logic       o_ctrl_read_valid;
  logic       o_ctrl_done;
  logic [6:0] o_driver_addr;
  logic [15:0] o_operation_addr;
  logic [7:0] o_operation_len;
  logic       o_operation_type;
  logic       o_operation_valid;
  logic       i_operation_ready;
  logic [7:0] o_write_data;
  logic       i_write_req;
  logic [7:0] i_read_data;
  logic       i_read_valid;
  logic [2:0] dbg_state;

  eeprom_page_ctrl #(.P_TWR_CYCLES(TWR)) dut (
    .i_clk(i_clk), .i_rst_n(rst_n),
    .i_ctrl_eeprom_addr(i_ctrl_eeprom_addr), .i_ctrl_operation_addr(i_ctrl_operation_addr),
    .i_ctrl_operation_len(i_ctrl_operation_len), .i_ctrl_operation_type(i_ctrl_operation_type),
    .i_ctrl_operation_valid(i_ctrl_operation_valid), .o_ctrl_operation_ready(o_ctrl_operation_ready),
    .i_ctrl_write_data(i_ctrl_write_data), .i_ctrl_write_valid(i_ctrl_write_valid),
    .o_ctrl_write_ready(o_ctrl_write_ready), .o_ctrl_read_data(o_ctrl_read_data),
    .o_ctrl_read_valid(o_ctrl_read_valid), .o_ctrl_done(o_ctrl_done),
    .o_driver_addr(o_driver_addr), .o_operation_addr(o_operation_addr),
    .o_operation_len(o_operation_len), .o_operation_type(o_operation_type),
    .o_operation_valid(o_operation_valid), .i_operation_ready(i_operation_ready),
    .o_write_data(o_write_data), .i_write_req(i_write_req),
    .i_read_data(i_read_data), .i_read_valid(i_read_valid), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_cmd_q[$];   // {type, driver addr, start addr, len}
  logic [7:0]  exp_q[$];       // bytes expected on o_write_data, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Model: writes are cut at every page boundary, reads go out as a single command.
  function automatic void plan(input logic [2:0] dev, input int addr, input int len, input bit typ);
    int a = addr;
    int r = len;
    int n;
    if (len == 0) return;
    if (typ) begin
      exp_cmd_q.push_back({1'b1, 4'b1010, dev, 16'(addr), 8'(len)});
      return;
    end
    while (r > 0) begin
      n = PAGE - (a % PAGE);
      if (n > r) n = r;
      exp_cmd_q.push_back({1'b0, 4'b1010, dev, 16'(a), 8'(n)});
      a = (a + n) % 65536;
      r = r - n;
    end
  endfunction

  // ---------------- driver model ----------------
  bit drv_hold = 1'b0;
  bit drv_busy = 1'b0;
  int rise_cyc = 0;
  int cmd_cyc  = 0;
  int n_cmds   = 0;
  int n_echo   = 0;

  initial begin
    logic [31:0] got;
    int n;
    bit is_rd;
    i_operation_ready = 1'b1;
    i_write_req       = 1'b0;
    i_read_valid      = 1'b0;
    i_read_data       = '0;
    forever begin
      @(negedge i_clk);
      if (rst_n && o_operation_valid && i_operation_ready) begin
        got = {o_operation_type, o_driver_addr, o_operation_addr, o_operation_len};
        cmd_cyc = cyc;
        n_cmds++;
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("FAIL drv_cmd: got unexpected command 0x%08h", got);
        end else begin
          check("drv_cmd", got, exp_cmd_q.pop_front());
        end
        n = int'(o_operation_len);
        is_rd = o_operation_type;
        @(posedge i_clk); #1;
        i_operation_ready = 1'b0;
        drv_busy = 1'b1;
        @(negedge i_clk);
        if (rst_n) check("valid_drop", {31'b0, o_operation_valid}, 32'd0);
        if (drv_hold) begin
          for (int k = 0; k < 2000 && rst_n; k++) @(negedge i_clk);
        end else if (is_rd) begin
          for (int k = 0; k < n && rst_n; k++) begin
            @(posedge i_clk); #1;
            i_read_data  = 8'($urandom_range(0, 255));
            i_read_valid = 1'b1;
            @(posedge i_clk); #1;
            i_read_valid = 1'b0;
          end
        end else begin
          @(posedge i_clk); #1;
          for (int k = 0; k < n && rst_n; k++) begin
            i_write_req = 1'b1;
            @(posedge i_clk); #1;
            if (exp_q.size() == 0) fail_now("wr_byte_underflow");
            else check("wr_byte", {24'b0, o_write_data}, {24'b0, exp_q.pop_front()});
          end
          i_write_req = 1'b0;
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_operation_ready = 1'b1;
        rise_cyc = cyc + 1;
        drv_busy = 1'b0;
      end
    end
  end

  // Read path: whatever the driver presented last cycle must appear now.
  initial begin
    bit prv = 1'b0;
    logic [7:0] prd = '0;
    forever begin
      @(negedge i_clk);
      if (!rst_n) begin
        prv = 1'b0;
      end else begin
        if (prv || o_ctrl_read_valid) begin
          check("rd_echo_valid", {31'b0, o_ctrl_read_valid}, {31'b0, prv});
          if (prv) check("rd_echo_data", {24'b0, o_ctrl_read_data}, {24'b0, prd});
          if (o_ctrl_read_valid) n_echo++;
        end
        prv = i_read_valid;
        prd = i_read_data;
      end
    end
  end

  // ---------------- host driver tasks ----------------
  int last_push_cyc = 0;
  int done_cyc = 0;
  int done_lat = 0;

  task automatic push_bytes(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      b = 8'($urandom_range(0, 255));
      i_ctrl_write_data  = b;
      i_ctrl_write_valid = 1'b1;
      @(negedge i_clk);
      check("write_ready", {31'b0, o_ctrl_write_ready}, 32'd1);
      @(posedge i_clk); #1;
      i_ctrl_write_valid = 1'b0;
      exp_q.push_back(b);
      last_push_cyc = cyc;
    end
  endtask

  task automatic issue(input logic [2:0] dev, input logic [15:0] addr, input logic [7:0] len,
                       input bit typ);
    int w = 0;
    @(posedge i_clk); #1;
    i_ctrl_eeprom_addr     = dev;
    i_ctrl_operation_addr  = addr;
    i_ctrl_operation_len   = len;
    i_ctrl_operation_type  = typ;
    i_ctrl_operation_valid = 1'b1;
    do begin
      @(negedge i_clk);
      w++;
    end while (!o_ctrl_operation_ready && w < 200);
    if (!o_ctrl_operation_ready) fail_now("cmd_handshake");
    @(posedge i_clk); #1;
    i_ctrl_operation_valid = 1'b0;
    @(negedge i_clk);
    check("ready_low_after_hs", {31'b0, o_ctrl_operation_ready}, 32'd0);
  endtask

  task automatic wait_done();
    int lat = 1;
    while (!o_ctrl_done && lat < 3000) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_ctrl_done) begin
      fail_now("done_timeout");
    end else begin
      done_cyc = cyc;
      done_lat = lat;
      check("ready_low_in_done", {31'b0, o_ctrl_operation_ready}, 32'd0);
      @(negedge i_clk);
      check("done_one_cycle", {31'b0, o_ctrl_done}, 32'd0);
      check("ready_after_done", {31'b0, o_ctrl_operation_ready}, 32'd1);
    end
  endtask

  task automatic do_cmd(input logic [2:0] dev, input logic [15:0] addr, input logic [7:0] len,
                        input bit typ);
    issue(dev, addr, len, typ);
    wait_done();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0;
    int e0;
    int w;
    i_ctrl_eeprom_addr     = '0;
    i_ctrl_operation_addr  = '0;
    i_ctrl_operation_len   = '0;
    i_ctrl_operation_type  = 1'b0;
    i_ctrl_operation_valid = 1'b0;
    i_ctrl_write_data      = '0;
    i_ctrl_write_valid     = 1'b0;

    repeat (3) @(negedge i_clk);
    check("rst_op_ready",    {31'b0, o_ctrl_operation_ready}, 32'd1);
    check("rst_write_ready", {31'b0, o_ctrl_write_ready}, 32'd1);
    check("rst_op_valid",    {31'b0, o_operation_valid}, 32'd0);
    check("rst_done",        {31'b0, o_ctrl_done}, 32'd0);
    check("rst_read_valid",  {31'b0, o_ctrl_read_valid}, 32'd0);
    check("rst_drv_fields",  {o_operation_type, o_driver_addr, o_operation_addr, o_operation_len}, 32'd0);
    check("rst_write_data",  {24'b0, o_write_data}, 32'd0);
    @(posedge i_clk); #2;
    rst_n = 1'b1;

    // single in-page write, data buffered before the command
    push_bytes(4);
    plan(3'b011, 16'h0010, 4, 1'b0);
    check("pin_s1_cmd", exp_cmd_q[0], 32'h5300_1004);
    do_cmd(3'b011, 16'h0010, 8'd4, 1'b0);
    check("s1_twr_to_done", 32'(done_cyc - rise_cyc), 32'(TWR));
    check("s1_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
    check("s1_bytes_left", 32'(exp_q.size()), 32'd0);

    // write crossing two page boundaries, data streamed alongside
    push_bytes(6);
    plan(3'b000, 16'h000E, 20, 1'b0);
    check("pin_s2_cmd0", exp_cmd_q[0], 32'h5000_0E02);
    check("pin_s2_cmd1", exp_cmd_q[1], 32'h5000_1010);
    check("pin_s2_cmd2", exp_cmd_q[2], 32'h5000_2002);
    c0 = n_cmds;
    fork
      do_cmd(3'b000, 16'h000E, 8'd20, 1'b0);
      push_bytes(14);
    join
    check("s2_cmd_count", 32'(n_cmds - c0), 32'd3);
    check("s2_twr_to_done", 32'(done_cyc - rise_cyc), 32'(TWR));
    check("s2_bytes_left", 32'(exp_q.size()), 32'd0);

    // sequential read across a page boundary
    plan(3'b111, 16'h00FE, 5, 1'b1);
    check("pin_s3_cmd", exp_cmd_q[0], 32'hD700_FE05);
    e0 = n_echo;
    do_cmd(3'b111, 16'h00FE, 8'd5, 1'b1);
    check("s3_done_on_rise", 32'(done_cyc - rise_cyc), 32'd0);
    check("s3_echo_count", 32'(n_echo - e0), 32'd5);

    // zero-length command completes without touching the driver
    c0 = n_cmds;
    do_cmd(3'b001, 16'h0100, 8'd0, 1'b0);
    check("s4_done_latency", 32'(done_lat), 32'd2);
    check("s4_no_driver_cmd", 32'(n_cmds - c0), 32'd0);

    // partial fill: no driver write until all 8 bytes are buffered
    plan(3'b010, 16'h0030, 8, 1'b0);
    c0 = n_cmds;
    fork
      do_cmd(3'b010, 16'h0030, 8'd8, 1'b0);
      begin
        push_bytes(3);
        repeat (100) @(posedge i_clk);
        check("s5_no_early_req", 32'(n_cmds - c0), 32'd0);
        push_bytes(5);
      end
    join
    check("s5_req_after_fill",
          32'((cmd_cyc - last_push_cyc >= 1) && (cmd_cyc - last_push_cyc <= 3)), 32'd1);
    check("s5_bytes_left", 32'(exp_q.size()), 32'd0);

    // reset while the driver is busy writing, then a normal read
    push_bytes(4);
    plan(3'b001, 16'h0040, 4, 1'b0);
    drv_hold = 1'b1;
    issue(3'b001, 16'h0040, 8'd4, 1'b0);
    w = 0;
    while (!drv_busy && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (!drv_busy) fail_now("s6_driver_accept");
    repeat (3) @(posedge i_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_op_ready",    {31'b0, o_ctrl_operation_ready}, 32'd1);
    check("s6_rst_write_ready", {31'b0, o_ctrl_write_ready}, 32'd1);
    check("s6_rst_op_valid",    {31'b0, o_operation_valid}, 32'd0);
    check("s6_rst_done",        {31'b0, o_ctrl_done}, 32'd0);
    check("s6_rst_write_data",  {24'b0, o_write_data}, 32'd0);
    check("s6_rst_drv_fields",  {o_operation_type, o_driver_addr, o_operation_addr, o_operation_len}, 32'd0);
    exp_q.delete();
    exp_cmd_q.delete();
    drv_hold = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    rst_n = 1'b1;
    w = 0;
    while (drv_busy && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    plan(3'b001, 16'h0123, 3, 1'b1);
    e0 = n_echo;
    do_cmd(3'b001, 16'h0123, 8'd3, 1'b1);
    check("s6_read_echo_count", 32'(n_echo - e0), 32'd3);
    check("s6_cmds_left", 32'(exp_cmd_q.size()), 32'd0);

    repeat (5) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
